// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op codes,
// FSM state encoding, iteration modes and the default datapath width.
package mdu_ctrl_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_SIGNFIX = 2'd2,
        ST_DONE    = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath, purely combinational.
// Multiply: acc = {partial product, remaining multiplier bits}; add the
// multiplicand when the lsb is set, then shift right by one.
// Divide: acc = {partial remainder, dividend/quotient bits}; shift left,
// subtract the divisor if it fits and shift in the quotient bit.
module mdu_iter_step
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               mode_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;

    // Both candidate results are formed; the mode selects one.
    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        // The remainder after a successful subtract is below the divisor,
        // so WIDTH bits are enough for the difference.
        rem_sub = rem_sh[WIDTH-1:0] - operand_i;
        if (mode_i == MODE_DIV) begin
            if (rem_sh >= {1'b0, operand_i}) begin
                acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller. It sequences the shared
// one-bit-per-cycle datapath, applies the sign correction and owns HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               op_signed, op_div, in_sign_a, in_sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc, acc_neg;

    // Decode the incoming op and take operand magnitudes. The magnitude of
    // -2^WIDTH-1 is read as unsigned, so it stays exact.
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign in_sign_a = op_signed & a[WIDTH-1];
    assign in_sign_b = op_signed & b[WIDTH-1];
    assign mag_a     = in_sign_a ? -a : a;
    assign mag_b     = in_sign_b ? -b : b;
    assign acc_neg   = -acc_q;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .mode_i    (is_div_q ? MODE_DIV : MODE_MUL),
        .acc_o     (step_acc)
    );

    // Next-state and datapath update for the controller FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !flush) begin
                    is_div_d   = op_div;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    div_zero_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_CALC;
                    if (op_div) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                        if (b == '0) begin
                            state_d    = ST_DONE;
                            div_zero_d = 1'b1;
                        end
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end else begin
                    state_d = ST_IDLE;
                    // A start in the same cycle always drops MTHI/MTLO.
                    if (!start) begin
                        if (hi_we) hi_d = wdata;
                        if (lo_we) lo_d = wdata;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_SIGNFIX;
                end
            end
            ST_SIGNFIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (is_div_q) begin
                        lo_d = (sign_a_q ^ sign_b_q) ? acc_neg[WIDTH-1:0]
                                                     : acc_q[WIDTH-1:0];
                        hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH]
                                        : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_d = (sign_a_q ^ sign_b_q) ? acc_neg[2*WIDTH-1:WIDTH]
                                                     : acc_q[2*WIDTH-1:WIDTH];
                        lo_d = (sign_a_q ^ sign_b_q) ? acc_neg[WIDTH-1:0]
                                                     : acc_q[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == ST_CALC) || (state_q == ST_SIGNFIX);
    assign stall    = busy & hilo_rd;
    assign done     = (state_q == ST_DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes expected results from an
// arithmetic reference model, the monitor checks outputs every cycle.
`timescale 1ns/1ps
module tb_mdu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0, hilo_rd = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         busy, stall, done, div_zero;
    logic [W-1:0] hi, lo;

    mdu_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hilo_rd(hilo_rd), .busy(busy), .stall(stall), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_edge;
    } exp_t;

    exp_t        scb[$];
    int          edge_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          check_busy = 1'b1;
    logic [31:0] hi_m = '0, lo_m = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural values.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        e.op = o; e.a = aa; e.b = bb; e.dz = 1'b0;
        e.hi = hi_m; e.lo = lo_m; e.done_edge = 0;
        sa  = longint'($signed(aa));
        sbv = longint'($signed(bb));
        case (o)
            2'b00: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'd0, aa} * {32'd0, bb}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (bb == 32'd0) begin
                    e.dz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sbv; r = sa % sbv;
                    e.lo = 32'(q); e.hi = 32'(r);
                end else begin
                    e.lo = aa / bb; e.hi = aa % bb;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: busy/stall/done every cycle, result fields on each done.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (!rst) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (scb.size() > 0) begin
                exp_busy = !scb[0].dz && edge_cnt >= scb[0].done_edge - 33
                           && edge_cnt < scb[0].done_edge;
                exp_done = (edge_cnt == scb[0].done_edge);
            end
            if (check_busy) begin
                check("busy", 64'(busy), 64'(exp_busy));
                check("stall", 64'(stall), 64'(exp_busy & hilo_rd));
            end
            check("done", 64'(done), 64'(exp_done));
            if (exp_done) begin
                check("hi", 64'(hi), 64'(scb[0].hi));
                check("lo", 64'(lo), 64'(scb[0].lo));
                check("div_zero", 64'(div_zero), 64'(scb[0].dz));
                $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b",
                         scb[0].op, scb[0].a, scb[0].b, hi, lo, div_zero);
                void'(scb.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        hilo_rd = 1'($urandom_range(0, 1));
    endtask

    // Drive one start (called just after a rising edge); returns the edge
    // count at which DONE is expected.
    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input bit score, input bit with_we, output int d_edge);
        exp_t e;
        op = o; a = aa; b = bb; start = 1'b1;
        hi_we = with_we; lo_we = with_we; wdata = 32'hDEADBEEF;
        e = model(o, aa, bb);
        e.done_edge = edge_cnt + (e.dz ? 1 : 34);
        d_edge = e.done_edge;
        if (score) begin
            scb.push_back(e);
            hi_m = e.hi;
            lo_m = e.lo;
        end
        cycle();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input int gap);
        int d;
        issue(o, aa, bb, 1'b1, 1'b0, d);
        while (edge_cnt < d) cycle();
        repeat (gap) cycle();
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] data);
        hi_we = h; lo_we = l; wdata = data;
        if (h) hi_m = data;
        if (l) lo_m = data;
        cycle();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_hi", 64'(hi), 64'(hi_m));
        check("mt_lo", 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d;
        rst = 1'b1;
        hilo_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_dz", 64'(div_zero), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        rst = 1'b0;
        cycle();

        // Directed cases, including the signed corner cases.
        run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        run(2'b00, 32'hFFFFFFFD, 32'd5, 0);
        run(2'b10, 32'hFFFFFFF9, 32'd2, 2);
        run(2'b11, 32'd100, 32'd7, 0);
        run(2'b00, 32'h80000000, 32'h80000000, 1);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF, 1);

        // Divide by zero with preloaded HI/LO; MTHI/MTLO alongside start is dropped.
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        issue(2'b11, 32'd100, 32'd0, 1'b1, 1'b1, d);
        while (edge_cnt < d) cycle();
        cycle();
        check("dz_sticky", 64'(div_zero), 64'h1);
        check("dz_hi_kept", 64'(hi), 64'h11);
        check("dz_lo_kept", 64'(lo), 64'h22);

        // Flush mid-calculation: no done, HI/LO untouched, then a normal op.
        check_busy = 1'b0;
        issue(2'b01, $urandom, $urandom, 1'b0, 1'b0, d);
        repeat (9) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_hi", 64'(hi), 64'(hi_m));
        check("flush_lo", 64'(lo), 64'(lo_m));
        check_busy = 1'b1;
        run(2'b00, 32'hFFFFFF00, 32'h00001234, 0);

        // Randomized operations, some issued back-to-back in the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            run(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a calculation.
        check_busy = 1'b0;
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, d);
        repeat (5) cycle();
        #1;
        rst = 1'b1;
        #1;
        check("arst_hi", 64'(hi), 64'h0);
        check("arst_lo", 64'(lo), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        hi_m = '0;
        lo_m = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_busy = 1'b1;
        cycle();
        run(2'b11, 32'd1000, 32'd33, 2);

        check("scoreboard_empty", 64'(scb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide controller for the EX stage. Sequences a shared 32-cycle shift-add/restoring-divide datapath for MULT/MULTU/DIV/DIVU and owns the HI/LO registers.
- Stalls the pipeline when a HI/LO read reaches EX while an operation is in flight.
- Sits beside the ALU. It is fed by the same rs/rt operands, and its start/op come from ID/EX control.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE or DONE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand/dividend)
- b  in  WIDTH  rt operand (multiplier/divisor)
- flush  in  1  abandon in-flight operation
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- hilo_rd  in  1  MFHI/MFLO currently in EX
- busy  out  1  high in CALC or SIGNFIX
- stall  out  1  busy & hilo_rd, combinational
- done  out  1  one-cycle pulse; high in DONE state
- div_zero  out  1  last DIV/DIVU had b==0; sticky until next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE, hi=lo=0, counter=0, div_zero=0, done=0, busy=0. Internal accumulators are cleared.
- States: IDLE, CALC, SIGNFIX, DONE.
- IDLE/DONE, start=1:
  - Latch the operand magnitudes: the absolute value for signed ops, raw for unsigned.
  - Latch the operand signs and op. Clear div_zero and set counter=0.
  - Next state is CALC, except DIV/DIVU with b==0: next state is DONE, div_zero=1, hi/lo unchanged.
- IDLE/DONE, start=0: DONE goes to IDLE. IDLE holds.
- CALC: performs one iteration per cycle and increments the counter. When counter==WIDTH-1, the next state is SIGNFIX.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle.
- SIGNFIX, multiply: negate the 64-bit product if the operand signs differ. Write hi=product[63:32], lo=product[31:0]. Next state is DONE.
- SIGNFIX, divide: lo = quotient, negated if the signs differ. hi = remainder, taking the sign of the dividend. Next state is DONE.
- Latency: start sampled at edge of cycle k. busy is high in cycles k+1..k+33. hi/lo are valid and done=1 in cycle k+34. A back-to-back start is allowed in k+34.
- flush: in CALC/SIGNFIX, the next state is IDLE, hi/lo are not written, and there is no done pulse. In IDLE/DONE, flush suppresses start that cycle.
- start while busy: ignored; the pipeline guarantees a stall.
- hi_we/lo_we: honoured only in IDLE/DONE and ignored while busy. If start=1 in the same cycle, start wins and the write is dropped.
- Signed edge case: MULT with 0x80000000 magnitude uses a 33-bit-safe unsigned path, so -2^31 * -2^31 gives hi=0x40000000, lo=0.
- DIV -2^31 / -1: result is truncated modulo 2^32, giving lo=0x80000000, hi=0.

Decomposition:
- Shared header mdu_defs.vh holds:
  - op encodings MDU_MULT/MULTU/DIV/DIVU;
  - state encodings;
  - WIDTH default.
- One sub-module, mdu_iter_step: a combinational single-iteration step (shift-add or subtract-compare) taking {acc, operand, mode} and returning the next acc. The FSM, counter, sign handling and HI/LO remain in mdu_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF start@k -> busy k+1..k+33; done@k+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div_zero=0.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU 100/7 -> lo=14, hi=2.
- DIVU a=100 b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> done@k+1, busy never high, div_zero=1, hi=0x11, lo=0x22.
- MULTU start@k, flush@k+10 -> IDLE@k+11, busy=0, no done, hi/lo keep prior values. A start@k+11 completes normally.
- hilo_rd=1 during CALC -> stall=1, and stall=0 in DONE. hi_we with start in the same cycle -> write dropped. rst asserted mid-CALC -> hi=lo=0, busy=0 immediately, without a clock edge.
